display_scan: RTL and testbench



---
 rtl/display_scan_pkg.sv | 9 +
 rtl/display_scan_if.sv | 24 ++
 rtl/display_scan_prescaler.sv | 33 +++
 rtl/display_scan.sv | 100 ++++++++++
 tb/tb_display_scan.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/display_scan_pkg.sv
// Shared constants and types for the seven-segment scan controller and its helpers.
package display_pkg;
    localparam int NUM_DIGITS_DEFAULT = 4;
    localparam int DIGIT_W            = 4;

    typedef logic [$clog2(NUM_DIGITS_DEFAULT)-1:0] digit_idx_t;

    localparam logic [NUM_DIGITS_DEFAULT-1:0] ANODES_OFF = '1;
endpackage

// File: rtl/display_scan_if.sv
// Data/display bundle between a value producer (master) and display_scan (slave).
interface display_scan_if
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEFAULT
);
    logic                          load;
    logic [DIGIT_W*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]         blank_mask;
    logic [DIGIT_W-1:0]            digit_nibble;
    logic [NUM_DIGITS-1:0]         an_n;
    logic                          pending;
    logic                          frame_tick;

    modport master (
        output load, value, blank_mask,
        input  digit_nibble, an_n, pending, frame_tick
    );

    modport slave (
        input  load, value, blank_mask,
        output digit_nibble, an_n, pending, frame_tick
    );
endinterface

// File: rtl/display_scan_prescaler.sv
// Slot prescaler: free-running 0..DIV_MAX-1 counter with slot-end and dead-window flags.
module scan_prescaler #(
    parameter int DIV_MAX     = 2000,
    parameter int DIV_WIDTH   = 11,
    parameter int DEAD_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic slot_end_o,
    output logic dead_o
);
    localparam logic [DIV_WIDTH-1:0] CNT_LAST = DIV_WIDTH'(DIV_MAX - 1);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

    assign slot_end_o = (cnt_q == CNT_LAST);
    assign cnt_d      = slot_end_o ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // A zero-length dead window would make the compare constant-false.
    generate
        if (DEAD_CYCLES == 0) begin : g_no_dead
            assign dead_o = 1'b0;
        end else begin : g_dead
            localparam logic [DIV_WIDTH-1:0] DEAD_END = DIV_WIDTH'(DEAD_CYCLES);
            assign dead_o = (cnt_q < DEAD_END);
        end
    endgenerate
endmodule

// File: rtl/display_scan.sv
// Multiplexed 7-seg scan controller with double-buffered value and per-slot dead time.
// Optional leading-zero suppression: define DISPLAY_SCAN_LEADING_ZERO_BLANK_EN.
module display_scan
    import display_pkg::*;
#(
    parameter int NUM_DIGITS  = NUM_DIGITS_DEFAULT,
    parameter int DIV_MAX     = 2000,
    parameter int DIV_WIDTH   = 11,
    parameter int DEAD_CYCLES = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    display_scan_if.slave  bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W = DIGIT_W * NUM_DIGITS;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [VAL_W-1:0]      active_q, active_d;
    logic [VAL_W-1:0]      shadow_q, shadow_d;
    logic                  pending_q, pending_d;
    logic                  frame_tick_q;
    logic                  slot_end, dead, boundary;
    logic [DIGIT_W-1:0]    nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] suppress;
    logic [NUM_DIGITS-1:0] lit;

    scan_prescaler #(
        .DIV_MAX    (DIV_MAX),
        .DIV_WIDTH  (DIV_WIDTH),
        .DEAD_CYCLES(DEAD_CYCLES)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .slot_end_o(slot_end),
        .dead_o    (dead)
    );

    assign boundary = slot_end && (idx_q == IDX_LAST);

    // A load landing on the boundary bypasses the shadow so it is not a frame late.
    always_comb begin
        idx_d     = idx_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        if (boundary) begin
            if (bus.load) begin
                active_d  = bus.value;
                shadow_d  = bus.value;
                pending_d = 1'b0;
            end else if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
        end else if (bus.load) begin
            shadow_d  = bus.value;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q        <= '0;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            frame_tick_q <= boundary;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nib[gi] = active_q[gi*DIGIT_W +: DIGIT_W];
`ifdef DISPLAY_SCAN_LEADING_ZERO_BLANK_EN
            if (gi == 0) begin : g_lsd
                assign suppress[gi] = 1'b0;
            end else begin : g_upper
                assign suppress[gi] = (active_q[VAL_W-1:gi*DIGIT_W] == '0);
            end
`else
            assign suppress[gi] = 1'b0;
`endif
            assign lit[gi] = (idx_q == IDX_W'(gi)) && !bus.blank_mask[gi] && !suppress[gi];
        end
    endgenerate

    assign bus.digit_nibble = nib[idx_q];
    assign bus.an_n         = dead ? {NUM_DIGITS{ANODES_OFF[0]}} : ~lit;
    assign bus.pending      = pending_q;
    assign bus.frame_tick   = frame_tick_q;
endmodule

// File: tb/tb_display_scan.sv
// Scoreboard bench for display_scan: directed stimulus pushes cycle-tagged expectations, a monitor checks them.
module tb_display_scan;
    import display_pkg::*;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [3:0] nib;
        logic       pend;
        logic       ft;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    display_scan_if #(.NUM_DIGITS(4)) dif ();

    display_scan #(
        .NUM_DIGITS (4),
        .DIV_MAX    (4),
        .DIV_WIDTH  (2),
        .DEAD_CYCLES(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (dif)
    );

    always #5 clk = ~clk;

    // Cycles since reset release: state at cycle k has prescaler k%4, idx (k/4)%4.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic ex(input int c, input logic [3:0] an, input logic [3:0] nib,
                      input logic pend, input logic ft);
        exp_t e;
        e.cyc = c; e.an = an; e.nib = nib; e.pend = pend; e.ft = ft;
        exp_q.push_back(e);
    endtask

    task automatic wait_cycle(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic load_at(input int k, input logic [15:0] v);
        wait_cycle(k);
        dif.load  = 1'b1;
        dif.value = v;
        wait_cycle(k + 1);
        dif.load  = 1'b0;
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            mon_e = exp_q.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL stale: expectation for cyc %0d never checked (now cyc %0d)", mon_e.cyc, cyc);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            mon_e = exp_q.pop_front();
            n_vec++;
            if (dif.an_n !== mon_e.an || dif.digit_nibble !== mon_e.nib ||
                dif.pending !== mon_e.pend || dif.frame_tick !== mon_e.ft) begin
                n_bad++;
                $display("FAIL cyc%0d: got an_n=%b nib=%h pend=%b ft=%b, want an_n=%b nib=%h pend=%b ft=%b",
                         cyc, dif.an_n, dif.digit_nibble, dif.pending, dif.frame_tick,
                         mon_e.an, mon_e.nib, mon_e.pend, mon_e.ft);
            end else begin
                $display("ok   cyc%0d: an_n=%b nib=%h pend=%b ft=%b",
                         cyc, dif.an_n, dif.digit_nibble, dif.pending, dif.frame_tick);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        dif.load       = 1'b0;
        dif.value      = '0;
        dif.blank_mask = '0;
        #1 rst_n = 1'b0;

        // Reset state, then free-run scan of an all-zero value
        ex(0, 4'hF, 4'h0, 0, 0);
        ex(1, 4'hE, 4'h0, 0, 0);  ex(3, 4'hE, 4'h0, 0, 0);
        ex(4, 4'hF, 4'h0, 0, 0);  ex(5, 4'hD, 4'h0, 0, 0);
        ex(9, 4'hB, 4'h0, 0, 0);  ex(13, 4'h7, 4'h0, 0, 0);
        ex(15, 4'h7, 4'h0, 0, 0); ex(16, 4'hF, 4'h0, 0, 1);
        ex(17, 4'hE, 4'h0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Mid-frame load of 1234 waits for the boundary
        wait_cycle(18);
        ex(19, 4'hE, 4'h0, 1, 0); ex(20, 4'hF, 4'h0, 1, 0);
        ex(31, 4'h7, 4'h0, 1, 0); ex(32, 4'hF, 4'h4, 0, 1);
        ex(33, 4'hE, 4'h4, 0, 0);
        load_at(18, 16'h1234);

        // Two loads in one frame: last wins
        wait_cycle(34);
        ex(37, 4'hD, 4'h3, 1, 0); ex(41, 4'hB, 4'h2, 1, 0);
        ex(45, 4'h7, 4'h1, 1, 0); ex(48, 4'hF, 4'h5, 0, 1);
        ex(49, 4'hE, 4'h5, 0, 0); ex(53, 4'hD, 4'h5, 0, 0);
        ex(57, 4'hB, 4'h5, 0, 0); ex(61, 4'h7, 4'h5, 0, 0);
        ex(63, 4'h7, 4'h5, 0, 0);
        load_at(34, 16'hAAAA);
        load_at(40, 16'h5555);

        // Load exactly on the boundary cycle bypasses the shadow
        wait_cycle(63);
        ex(64, 4'hF, 4'hF, 0, 1); ex(65, 4'hE, 4'hF, 0, 0);
        load_at(63, 16'hBEEF);

        // Reload 1234 for the blanking test
        wait_cycle(66);
        ex(69, 4'hD, 4'hE, 1, 0); ex(73, 4'hB, 4'hE, 1, 0);
        ex(77, 4'h7, 4'hB, 1, 0); ex(80, 4'hF, 4'h4, 0, 1);
        load_at(66, 16'h1234);

        // blank_mask on digit 2 keeps only that anode dark
        wait_cycle(81);
        ex(85, 4'hD, 4'h3, 0, 0); ex(86, 4'hD, 4'h3, 0, 0);
        ex(87, 4'hD, 4'h3, 0, 0); ex(88, 4'hF, 4'h2, 0, 0);
        ex(89, 4'hF, 4'h2, 0, 0); ex(91, 4'hF, 4'h2, 0, 0);
        ex(93, 4'h7, 4'h1, 0, 0);
        wait_cycle(86);
        dif.blank_mask = 4'b0100;
        wait_cycle(92);
        dif.blank_mask = 4'b0000;

        // Reset while a load is pending discards everything
        wait_cycle(94);
        ex(96, 4'hF, 4'h4, 0, 1); ex(99, 4'hE, 4'h4, 1, 0);
        load_at(98, 16'hAAAA);
        wait_cycle(100);
        rst_n = 1'b0;
        ex(0, 4'hF, 4'h0, 0, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        ex(1, 4'hE, 4'h0, 0, 0);  ex(5, 4'hD, 4'h0, 0, 0);
        ex(9, 4'hB, 4'h0, 0, 0);  ex(13, 4'h7, 4'h0, 0, 0);
        ex(16, 4'hF, 4'h0, 0, 1); ex(17, 4'hE, 4'h0, 0, 0);
        wait_cycle(18);

        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL leftover: %0d expectations unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
